// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the block-copy engine: FSM state encodings.
// The CPU control-port decode relies on these exact encodings.
package mem_copy_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// Word-granular block-copy engine acting as a bus initiator on the data RAM.
// Each word takes two cycles: a READ cycle that captures the RAM's
// asynchronous data_out, then a WRITE cycle that stores it at the destination.
//
// Command handshake: start is a single-cycle strobe with no ready signal.
// It is accepted only when the engine is idle (busy == 0) and rst is low.
// On the accepting edge, src_addr, dst_addr and length are captured.
// A start seen while busy is dropped, not queued. Completion is signalled
// by a one-cycle done pulse, after which busy falls.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output dma_state_e            dbg_state
);

  dma_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] buf_q;

  assign dbg_state = state_q;

  // State register plus the address/count/data registers they advance.
  // Address increments wrap naturally at the register width.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start && (length != '0)) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            cnt_q <= length;
          end
        end
        ST_READ: begin
          buf_q <= mem_rdata;
          src_q <= src_q + ADDR_WIDTH'(1);
        end
        ST_WRITE: begin
          dst_q <= dst_q + ADDR_WIDTH'(1);
          cnt_q <= cnt_q - LEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode; RAM port outputs depend only on the
  // registered state and registered values, so enables do not glitch.
  always_comb begin
    state_d          = state_q;
    busy             = (state_q != ST_IDLE);
    done             = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (length == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        mem_address     = src_q;
        mem_read_enable = 1'b1;
        state_d         = ST_WRITE;
      end
      ST_WRITE: begin
        mem_address      = dst_q;
        mem_data_in      = buf_q;
        mem_write_enable = 1'b1;
        state_d          = (cnt_q == LEN_WIDTH'(1)) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
